// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch responder sitting behind the PC block.
//
// Takes fetch addresses from the PC block (next_pc/next_pc_en) and issues
// them on the instruction-memory request/grant/response bus. Only one read
// is outstanding at a time. A fetched word is returned with a one-cycle
// inst_ready pulse. A bus error or a response timeout is returned with a
// one-cycle fetch_fault pulse. Addresses that arrive while a fetch is in
// progress go into a single-entry pending slot, and the newest one wins.
// A flush (branch redirect) kills the fetch in flight.
//
// Build option: IFETCH_ALIGN_CHECK_EN
//   defined   - a misaligned address (bits[1:0] != 0) faults with no bus request
//   undefined - address bits[1:0] are forced to zero, no check is made
//
// Ports:
//   clk, nrst             clock, synchronous active-low reset
//   next_pc, next_pc_en   fetch address and its single-cycle strobe
//   flush                 branch redirect (branch_addr_en)
//   inst_ready            one-cycle pulse: inst/inst_pc valid
//   inst, inst_pc         fetched word and its address (held)
//   fetch_fault           one-cycle pulse: error/timeout/misalign, inst_pc = address
//   busy                  fetch in progress or pending address held
//   imem_req, imem_addr   memory request (held until imem_gnt) and address
//   imem_gnt              request accepted
//   imem_rvalid, imem_rdata, imem_err   memory response
module ifetch_unit #(
  parameter int              DATA_W         = 32,
  parameter int              TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] RESET_INST   = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [31:0]       next_pc,
  input  logic              next_pc_en,
  input  logic              flush,
  output logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [31:0]       inst_pc,
  output logic              fetch_fault,
  output logic              busy,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam int            TW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          pend_vld;
  logic [31:0]   pend_addr;
  logic          acc_go;
  logic [31:0]   acc_addr;

  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

  assign busy = (state != IDLE) || pend_vld;

  // Address acceptance in IDLE: a live strobe beats the pending slot, and a
  // flush in the same cycle kills the pending address.
  always_comb begin
    acc_go   = 1'b0;
    acc_addr = next_pc;
    if (state == IDLE) begin
      if (next_pc_en) begin
        acc_go = 1'b1;
      end else if (pend_vld && !flush) begin
        acc_go   = 1'b1;
        acc_addr = pend_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    inst_ready  <= 1'b0;
    fetch_fault <= 1'b0;
    if (!nrst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
      inst      <= RESET_INST;
      inst_pc   <= 32'h0;
      pend_vld  <= 1'b0;
      pend_addr <= 32'h0;
      timer     <= '0;
    end else begin
      if (next_pc_en && state != IDLE) begin
        pend_vld  <= 1'b1;
        pend_addr <= next_pc;
      end else if (flush) begin
        pend_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (acc_go) begin
            pend_vld <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            if (acc_addr[1:0] != 2'b00) begin
              fetch_fault <= 1'b1;
              inst_pc     <= acc_addr;
            end else begin
              imem_addr <= acc_addr;
              imem_req  <= 1'b1;
              state     <= REQ;
            end
`else
            imem_addr <= align_addr(acc_addr);
            imem_req  <= 1'b1;
            state     <= REQ;
`endif
          end
        end

        REQ: begin
          if (imem_gnt) begin
            imem_req <= 1'b0;
            timer    <= '0;
            state    <= flush ? DRAIN : WAIT;
          end else if (flush) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end

        WAIT: begin
          timer <= timer + TW'(1);
          if (imem_rvalid) begin
            state <= IDLE;
            if (flush) begin
              // stale response: drop it silently
            end else if (imem_err) begin
              fetch_fault <= 1'b1;
              inst_pc     <= imem_addr;
            end else begin
              inst_ready <= 1'b1;
              inst       <= imem_rdata;
              inst_pc    <= imem_addr;
            end
          end else if (flush) begin
            state <= DRAIN;
          end else if (timer == TO_LAST) begin
            fetch_fault <= 1'b1;
            inst_pc     <= imem_addr;
            state       <= IDLE;
          end
        end

        default: begin
          // DRAIN: absorb the killed fetch's response; a timeout here is silent
          timer <= timer + TW'(1);
          if (imem_rvalid || timer == TO_LAST) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] next_pc;
  logic        next_pc_en;
  logic        flush;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic        busy;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  int errors = 0;
  int checks = 0;
  int rdy_cnt = 0;
  int flt_cnt = 0;
  int both_cnt = 0;

  ifetch_unit #(.DATA_W(32), .TIMEOUT_CYCLES(64), .RESET_INST(32'h0000_0013)) dut (
    .clk(clk), .nrst(nrst), .next_pc(next_pc), .next_pc_en(next_pc_en), .flush(flush),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .fetch_fault(fetch_fault),
    .busy(busy), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (inst_ready) rdy_cnt++;
    if (fetch_fault) flt_cnt++;
    if (inst_ready && fetch_fault) both_cnt++;
  endtask

  task automatic test_reset();
    nrst = 1'b0; next_pc = 32'h0; next_pc_en = 1'b0; flush = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
    cyc(); cyc();
    checks++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", inst_ready); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b want 0", fetch_fault); end
    checks++; if (inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst: got %h want 00000013", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    nrst = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    rdy_cnt = 0;
    next_pc = 32'h0000_0100; next_pc_en = 1'b1;
    cyc();
    next_pc_en = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %0b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL basic_addr: got %h want 00000100", imem_addr); end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %0b want 0", imem_req); end
    checks++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL basic_early_ready: got %0b want 0", inst_ready); end
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
    cyc();
    imem_rvalid = 1'b0;
    checks++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0b want 1", inst_ready); end
    checks++; if (inst !== 32'h00A0_0093) begin errors++; $display("FAIL basic_inst: got %h want 00a00093", inst); end
    checks++; if (inst_pc !== 32'h100) begin errors++; $display("FAIL basic_inst_pc: got %h want 00000100", inst_pc); end
    cyc();
    checks++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %0b want 0", inst_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %0b want 0", busy); end
    checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL basic_ready_count: got %0d want 1", rdy_cnt); end
  endtask

  task automatic test_stall();
    rdy_cnt = 0;
    next_pc = 32'h0000_0300; next_pc_en = 1'b1;
    cyc();
    next_pc_en = 1'b0; next_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL stall_hold_%0d: got req=%0b addr=%h want req=1 addr=00000300", i, imem_req, imem_addr); end
      cyc();
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL stall_hold_4: got req=%0b addr=%h want req=1 addr=00000300", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'h0030_0193;
    cyc();
    imem_rvalid = 1'b0;
    checks++; if (inst !== 32'h0030_0193 || inst_pc !== 32'h300) begin errors++; $display("FAIL stall_data: got inst=%h pc=%h want 00300193/00000300", inst, inst_pc); end
    cyc(); cyc();
    checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL stall_ready_count: got %0d want 1", rdy_cnt); end
  endtask

  task automatic test_flush_wait();
    rdy_cnt = 0;
    next_pc = 32'h0000_0200; next_pc_en = 1'b1;
    cyc();
    next_pc_en = 1'b0;
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    flush = 1'b1; next_pc_en = 1'b1; next_pc = 32'h0000_0400;
    cyc();
    flush = 1'b0; next_pc_en = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy: got %0b want 1", busy); end
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 1'b0;
    checks++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL flush_stale_ready: got %0b want 0", inst_ready); end
    cyc();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin errors++; $display("FAIL flush_new_req: got req=%0b addr=%h want req=1 addr=00000400", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h00B0_0113;
    cyc();
    imem_rvalid = 1'b0;
    checks++; if (inst_ready !== 1'b1 || inst_pc !== 32'h400) begin errors++; $display("FAIL flush_new_ready: got rdy=%0b pc=%h want rdy=1 pc=00000400", inst_ready, inst_pc); end
    checks++; if (inst !== 32'h00B0_0113) begin errors++; $display("FAIL flush_new_inst: got %h want 00b00113", inst); end
    cyc();
    checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL flush_ready_count: got %0d want 1", rdy_cnt); end
  endtask

  task automatic test_error();
    next_pc = 32'h0000_0500; next_pc_en = 1'b1;
    cyc();
    next_pc_en = 1'b0;
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_err = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    cyc();
    imem_rvalid = 1'b0; imem_err = 1'b0;
    checks++; if (fetch_fault !== 1'b1 || inst_ready !== 1'b0) begin errors++; $display("FAIL err_pulse: got fault=%0b rdy=%0b want fault=1 rdy=0", fetch_fault, inst_ready); end
    checks++; if (inst !== 32'h00B0_0113) begin errors++; $display("FAIL err_inst_kept: got %h want 00b00113", inst); end
    checks++; if (inst_pc !== 32'h500) begin errors++; $display("FAIL err_inst_pc: got %h want 00000500", inst_pc); end
    cyc();
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %0b want 0", fetch_fault); end
  endtask

  task automatic test_timeout();
    flt_cnt = 0;
    next_pc = 32'h0000_0600; next_pc_en = 1'b1;
    cyc();
    next_pc_en = 1'b0;
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    for (int i = 0; i < 63; i++) cyc();
    checks++; if (flt_cnt !== 0) begin errors++; $display("FAIL timeout_early: got %0d faults want 0", flt_cnt); end
    cyc();
    checks++; if (fetch_fault !== 1'b1 || inst_pc !== 32'h600) begin errors++; $display("FAIL timeout_fault: got fault=%0b pc=%h want fault=1 pc=00000600", fetch_fault, inst_pc); end
    cyc();
    checks++; if (busy !== 1'b0 || fetch_fault !== 1'b0) begin errors++; $display("FAIL timeout_after: got busy=%0b fault=%0b want 0/0", busy, fetch_fault); end
  endtask

  task automatic test_reset_midop();
    rdy_cnt = 0;
    next_pc = 32'h0000_0700; next_pc_en = 1'b1;
    cyc();
    next_pc_en = 1'b0;
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    nrst = 1'b0;
    cyc();
    nrst = 1'b1;
    checks++; if (imem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got req=%0b busy=%0b want 0/0", imem_req, busy); end
    checks++; if (inst !== 32'h0000_0013 || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_data: got inst=%h pc=%h addr=%h want 00000013/0/0", inst, inst_pc, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    cyc();
    imem_rvalid = 1'b0;
    cyc();
    checks++; if (rdy_cnt !== 0 || inst !== 32'h0000_0013 || busy !== 1'b0) begin errors++; $display("FAIL midrst_rvalid_ignored: got rdy_cnt=%0d inst=%h busy=%0b want 0/00000013/0", rdy_cnt, inst, busy); end
  endtask

  task automatic test_align();
    next_pc = 32'h0000_0102; next_pc_en = 1'b1;
    cyc();
    next_pc_en = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL align_no_req: got %0b want 0", imem_req); end
    checks++; if (fetch_fault !== 1'b1 || inst_pc !== 32'h102) begin errors++; $display("FAIL align_fault: got fault=%0b pc=%h want 1/00000102", fetch_fault, inst_pc); end
    cyc();
    checks++; if (busy !== 1'b0 || fetch_fault !== 1'b0) begin errors++; $display("FAIL align_after: got busy=%0b fault=%0b want 0/0", busy, fetch_fault); end
`else
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL align_forced: got req=%0b addr=%h want 1/00000100", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
    cyc();
    imem_rvalid = 1'b0;
    checks++; if (inst_ready !== 1'b1 || inst_pc !== 32'h100) begin errors++; $display("FAIL align_inst_pc: got rdy=%0b pc=%h want 1/00000100", inst_ready, inst_pc); end
    cyc();
`endif
  endtask

  task automatic test_exclusive();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive: got %0d overlapping pulses want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush_wait();
    test_error();
    test_timeout();
    test_reset_midop();
    test_align();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
